hough_peak_find: RTL and testbench

- Sits directly downstream of the Hough accumulator stage; consumes its raster-ordered accumulator stream (11-bit pixel, frame and line markers).
- Per frame, finds the maximum accumulator cell, its (row, col) position, and the number of cells at or above a vote threshold.
- Presents one result record per frame with a valid/ack handshake to the host or line-extraction logic.

---
 rtl/hough_peak_find.sv | 178 +++++++++++++++++
 tb/tb_hough_peak_find.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hough_peak_find.sv
// Per-frame peak finder for a raster-ordered Hough accumulator stream.
// Reports max cell, its (row, col) and the count of cells at or above THRESH.
module hough_peak_find #(
    parameter logic [7:0]  WIDTH  = 8'd180,
    parameter logic [7:0]  HEIGHT = 8'd128,
    parameter logic [10:0] THRESH = 11'd64
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic [10:0] PixelIn,
    input  logic        FrameIn,
    input  logic        LineIn,
    input  logic        ResultAck,
    output logic        ResultValid,
    output logic [10:0] PeakValue,
    output logic [7:0]  PeakRow,
    output logic [7:0]  PeakCol,
    output logic [15:0] AboveCount,
    output logic        Overrun,
    output logic        Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;

    logic [10:0] pixR;
    logic        frameR;
    logic        lineR;

    logic [7:0]  colQ;
    logic [7:0]  rowQ;
    logic [7:0]  curCol;
    logic [7:0]  curRow;
    logic        lastPix;
    logic        aboveThr;

    logic [10:0] wMax;
    logic [7:0]  wRow;
    logic [7:0]  wCol;
    logic [15:0] wCount;

    logic        loadStart;
    logic        accumulate;
    logic        doReport;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples values from before the edge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pixR   <= '0;
            frameR <= 1'b0;
            lineR  <= 1'b0;
        end else begin
            pixR   <= PixelIn;
            frameR <= FrameIn;
            lineR  <= LineIn;
        end
    end

    // Position of the registered pixel, derived from the previous one.
    always_comb begin
        curCol = colQ + 8'd1;
        if (lineR || frameR) begin
            curCol = '0;
        end
        curRow = rowQ;
        if (frameR) begin
            curRow = '0;
        end else if (lineR) begin
            curRow = rowQ + 8'd1;
        end
    end

    assign lastPix  = (curRow == HEIGHT - 8'd1) && (curCol == WIDTH - 8'd1);
    assign aboveThr = (pixR >= THRESH);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            colQ <= '0;
            rowQ <= '0;
        end else begin
            colQ <= curCol;
            rowQ <= curRow;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A frame start restarts scanning from any state, including REPORT.
    always_comb begin
        // NOTE: default assigned first so no path leaves nextState unassigned,
        // which would otherwise infer a latch.
        nextState = IDLE;
        if (frameR) begin
            nextState = lastPix ? REPORT : SCAN;
        end else if (state == SCAN) begin
            nextState = lastPix ? REPORT : SCAN;
        end
    end

    always_comb begin
        Busy       = 1'b0;
        loadStart  = frameR;
        accumulate = 1'b0;
        doReport   = 1'b0;
        case (state)
            SCAN: begin
                Busy       = 1'b1;
                accumulate = !frameR;
            end
            REPORT: begin
                doReport = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Strict compare keeps the first occurrence of a tied maximum.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wMax   <= '0;
            wRow   <= '0;
            wCol   <= '0;
            wCount <= '0;
        end else if (loadStart) begin
            wMax   <= pixR;
            wRow   <= curRow;
            wCol   <= curCol;
            wCount <= {15'd0, aboveThr};
        end else if (accumulate) begin
            if (pixR > wMax) begin
                wMax <= pixR;
                wRow <= curRow;
                wCol <= curCol;
            end
            if (aboveThr && (wCount != 16'hFFFF)) begin
                wCount <= wCount + 16'd1;
            end
        end
    end

    // A new report wins over a coincident ack; an unacked result is overrun.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            ResultValid <= 1'b0;
            PeakValue   <= '0;
            PeakRow     <= '0;
            PeakCol     <= '0;
            AboveCount  <= '0;
            Overrun     <= 1'b0;
        end else if (doReport) begin
            ResultValid <= 1'b1;
            PeakValue   <= wMax;
            PeakRow     <= wRow;
            PeakCol     <= wCol;
            AboveCount  <= wCount;
            if (ResultValid && !ResultAck) begin
                Overrun <= 1'b1;
            end
        end else if (ResultValid && ResultAck) begin
            ResultValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hough_peak_find.sv
// Bench for hough_peak_find: small 4x3 instance with a scoreboard, plus a
// 255x255 instance for the full-range count.
module tb_hough_peak_find;

    localparam int          W = 4;
    localparam int          H = 3;
    localparam logic [10:0] T = 11'd5;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [10:0] PixelIn = '0;
    logic        FrameIn = 1'b0;
    logic        LineIn = 1'b0;
    logic        ResultAck = 1'b0;
    logic        ResultValid;
    logic [10:0] PeakValue;
    logic [7:0]  PeakRow;
    logic [7:0]  PeakCol;
    logic [15:0] AboveCount;
    logic        Overrun;
    logic        Busy;

    logic [10:0] bPix = '0;
    logic        bFrame = 1'b0;
    logic        bLine = 1'b0;
    logic        bAck = 1'b0;
    logic        bValid;
    logic [10:0] bValue;
    logic [7:0]  bRow;
    logic [7:0]  bCol;
    logic [15:0] bCount;
    logic        bOverrun;
    logic        bBusy;

    typedef struct {
        logic [10:0] value;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] count;
        int          due;
    } expT;

    expT sbq[$];
    expT mon;
    int  cycle = 0;
    int  passCnt = 0;
    int  totalCnt = 0;

    hough_peak_find #(.WIDTH(8'd4), .HEIGHT(8'd3), .THRESH(11'd5)) dut (
        .Clk(Clk), .nReset(nReset), .PixelIn(PixelIn), .FrameIn(FrameIn),
        .LineIn(LineIn), .ResultAck(ResultAck), .ResultValid(ResultValid),
        .PeakValue(PeakValue), .PeakRow(PeakRow), .PeakCol(PeakCol),
        .AboveCount(AboveCount), .Overrun(Overrun), .Busy(Busy)
    );

    hough_peak_find #(.WIDTH(8'd255), .HEIGHT(8'd255), .THRESH(11'd0)) dutBig (
        .Clk(Clk), .nReset(nReset), .PixelIn(bPix), .FrameIn(bFrame),
        .LineIn(bLine), .ResultAck(bAck), .ResultValid(bValid),
        .PeakValue(bValue), .PeakRow(bRow), .PeakCol(bCol),
        .AboveCount(bCount), .Overrun(bOverrun), .Busy(bBusy)
    );

    always #5 Clk = ~Clk;

    // Scoreboard monitor: each expected record is due 2 edges after the
    // edge that samples its last pixel.
    always @(posedge Clk) begin
        cycle++;
        #1;
        if (sbq.size() > 0 && sbq[0].due == cycle) begin
            mon = sbq.pop_front();
            totalCnt++;
            if (ResultValid !== 1'b1) begin
                $display("FAIL result_valid_at_due: got %b want 1 (cycle %0d)", ResultValid, cycle);
            end else begin
                passCnt++;
            end
            totalCnt++;
            if ({PeakValue, PeakRow, PeakCol, AboveCount} !== {mon.value, mon.row, mon.col, mon.count}) begin
                $display("FAIL result_fields: got val=%0d row=%0d col=%0d cnt=%0d want val=%0d row=%0d col=%0d cnt=%0d",
                         PeakValue, PeakRow, PeakCol, AboveCount, mon.value, mon.row, mon.col, mon.count);
            end else begin
                passCnt++;
            end
        end
    end

    function automatic logic [10:0] pixVal(input int mode, input int r, input int c);
        case (mode)
            0:       return 11'(r * W + c);
            1:       return ((r == 0 && c == 2) || (r == 2 && c == 1)) ? 11'd9 : 11'd1;
            2:       return 11'(11 - (r * W + c));
            3:       return (r == 1 && c == 1) ? 11'd20 : 11'(c);
            default: return 11'd2000;
        endcase
    endfunction

    task automatic send_frame(input int mode);
        logic [10:0] p;
        expT         e;
        e.value = '0;
        e.row   = '0;
        e.col   = '0;
        e.count = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                p = pixVal(mode, r, c);
                if ((r == 0 && c == 0) || p > e.value) begin
                    e.value = p;
                    e.row   = 8'(r);
                    e.col   = 8'(c);
                end
                if (p >= T) e.count++;
                @(negedge Clk);
                PixelIn = p;
                FrameIn = (r == 0 && c == 0);
                LineIn  = (c == 0);
            end
        end
        e.due = cycle + 3;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            PixelIn = 11'($urandom_range(0, 2047));
            FrameIn = 1'b0;
            LineIn  = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 40) begin
            @(negedge Clk);
            k++;
        end
        totalCnt++;
        if (sbq.size() != 0) begin
            $display("FAIL %s_drain: %0d results outstanding, want 0", name, sbq.size());
            sbq.delete();
        end else begin
            passCnt++;
        end
    endtask

    task automatic ack_pulse();
        @(negedge Clk);
        ResultAck = 1'b1;
        @(negedge Clk);
        ResultAck = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        totalCnt++;
        if ({ResultValid, PeakValue, PeakRow, PeakCol, AboveCount, Overrun, Busy} !== '0) begin
            $display("FAIL reset_outputs: got rv=%b val=%0d row=%0d col=%0d cnt=%0d ovr=%b busy=%b want all 0",
                     ResultValid, PeakValue, PeakRow, PeakCol, AboveCount, Overrun, Busy);
        end else begin
            passCnt++;
        end
        nReset = 1'b1;
        idle(2);
    endtask

    task automatic test_ramp();
        send_frame(0);
        @(negedge Clk);
        totalCnt++;
        if ({Busy, ResultValid} !== 2'b10) begin
            $display("FAIL ramp_scan_busy: got busy=%b rv=%b want busy=1 rv=0", Busy, ResultValid);
        end else begin
            passCnt++;
        end
        @(negedge Clk);
        totalCnt++;
        if ({Busy, ResultValid} !== 2'b00) begin
            $display("FAIL ramp_report_early: got busy=%b rv=%b want busy=0 rv=0", Busy, ResultValid);
        end else begin
            passCnt++;
        end
        wait_drain("ramp");
        totalCnt++;
        if ({PeakValue, PeakRow, PeakCol, AboveCount, Overrun} !== {11'd11, 8'd2, 8'd3, 16'd7, 1'b0}) begin
            $display("FAIL ramp_values: got val=%0d row=%0d col=%0d cnt=%0d ovr=%b want 11 2 3 7 0",
                     PeakValue, PeakRow, PeakCol, AboveCount, Overrun);
        end else begin
            passCnt++;
        end
        ack_pulse();
        totalCnt++;
        if ({ResultValid, PeakValue} !== {1'b0, 11'd11}) begin
            $display("FAIL ramp_ack: got rv=%b val=%0d want rv=0 val=11", ResultValid, PeakValue);
        end else begin
            passCnt++;
        end
    endtask

    task automatic test_tie();
        idle(3);
        send_frame(1);
        wait_drain("tie");
        totalCnt++;
        if ({PeakValue, PeakRow, PeakCol} !== {11'd9, 8'd0, 8'd2}) begin
            $display("FAIL tie_first: got val=%0d row=%0d col=%0d want 9 0 2", PeakValue, PeakRow, PeakCol);
        end else begin
            passCnt++;
        end
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        idle(3);
        send_frame(0);
        send_frame(2);
        @(negedge Clk);
        @(negedge Clk);
        ResultAck = 1'b1;
        @(negedge Clk);
        ResultAck = 1'b0;
        totalCnt++;
        if ({ResultValid, Overrun} !== 2'b10) begin
            $display("FAIL b2b_report_vs_ack: got rv=%b ovr=%b want rv=1 ovr=0", ResultValid, Overrun);
        end else begin
            passCnt++;
        end
        wait_drain("b2b");
        ack_pulse();
        totalCnt++;
        if (ResultValid !== 1'b0) begin
            $display("FAIL b2b_ack: got rv=%b want 0", ResultValid);
        end else begin
            passCnt++;
        end
    endtask

    task automatic test_overrun();
        idle(3);
        send_frame(2);
        wait_drain("ovr_first");
        totalCnt++;
        if ({ResultValid, Overrun} !== 2'b10) begin
            $display("FAIL ovr_before: got rv=%b ovr=%b want rv=1 ovr=0", ResultValid, Overrun);
        end else begin
            passCnt++;
        end
        idle(3);
        send_frame(1);
        wait_drain("ovr_second");
        totalCnt++;
        if ({ResultValid, Overrun} !== 2'b11) begin
            $display("FAIL ovr_set: got rv=%b ovr=%b want rv=1 ovr=1", ResultValid, Overrun);
        end else begin
            passCnt++;
        end
        ack_pulse();
        totalCnt++;
        if ({ResultValid, Overrun, PeakValue} !== {1'b0, 1'b1, 11'd9}) begin
            $display("FAIL ovr_sticky: got rv=%b ovr=%b val=%0d want rv=0 ovr=1 val=9",
                     ResultValid, Overrun, PeakValue);
        end else begin
            passCnt++;
        end
    endtask

    task automatic test_abort();
        idle(3);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge Clk);
            PixelIn = pixVal(4, 0, 0);
            FrameIn = (i == 0);
            LineIn  = (i % W == 0);
        end
        send_frame(3);
        @(negedge Clk);
        @(negedge Clk);
        totalCnt++;
        if ({Busy, ResultValid} !== 2'b00) begin
            $display("FAIL abort_no_result: got busy=%b rv=%b want busy=0 rv=0", Busy, ResultValid);
        end else begin
            passCnt++;
        end
        wait_drain("abort");
        totalCnt++;
        if ({PeakValue, PeakRow, PeakCol, AboveCount} !== {11'd20, 8'd1, 8'd1, 16'd1}) begin
            $display("FAIL abort_restart: got val=%0d row=%0d col=%0d cnt=%0d want 20 1 1 1",
                     PeakValue, PeakRow, PeakCol, AboveCount);
        end else begin
            passCnt++;
        end
        ack_pulse();
    endtask

    task automatic test_reset_midscan();
        idle(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            PixelIn = 11'd300;
            FrameIn = (i == 0);
            LineIn  = (i % W == 0);
        end
        @(negedge Clk);
        FrameIn = 1'b0;
        LineIn  = 1'b0;
        #2;
        nReset = 1'b0;
        #1;
        totalCnt++;
        if ({ResultValid, PeakValue, PeakRow, PeakCol, AboveCount, Overrun, Busy} !== '0) begin
            $display("FAIL midscan_reset: got rv=%b val=%0d row=%0d col=%0d cnt=%0d ovr=%b busy=%b want all 0",
                     ResultValid, PeakValue, PeakRow, PeakCol, AboveCount, Overrun, Busy);
        end else begin
            passCnt++;
        end
        @(negedge Clk);
        nReset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            PixelIn = 11'($urandom_range(0, 2047));
            LineIn  = (i % W == 0);
        end
        @(negedge Clk);
        LineIn = 1'b0;
        repeat (3) @(negedge Clk);
        totalCnt++;
        if ({Busy, ResultValid} !== 2'b00) begin
            $display("FAIL midscan_ignore: got busy=%b rv=%b want busy=0 rv=0", Busy, ResultValid);
        end else begin
            passCnt++;
        end
        send_frame(0);
        wait_drain("post_reset");
        totalCnt++;
        if (Overrun !== 1'b0) begin
            $display("FAIL post_reset_overrun: got %b want 0", Overrun);
        end else begin
            passCnt++;
        end
        ack_pulse();
    endtask

    task automatic test_full_range();
        bPix = 11'd2047;
        for (int r = 0; r < 255; r++) begin
            for (int c = 0; c < 255; c++) begin
                @(negedge Clk);
                bFrame = (r == 0 && c == 0);
                bLine  = (c == 0);
            end
        end
        @(negedge Clk);
        bFrame = 1'b0;
        bLine  = 1'b0;
        @(negedge Clk);
        totalCnt++;
        if (bValid !== 1'b0) begin
            $display("FAIL big_early: got rv=%b want 0", bValid);
        end else begin
            passCnt++;
        end
        @(negedge Clk);
        totalCnt++;
        if ({bValid, bValue, bRow, bCol, bCount, bOverrun} !== {1'b1, 11'd2047, 8'd0, 8'd0, 16'd65025, 1'b0}) begin
            $display("FAIL big_frame: got rv=%b val=%0d row=%0d col=%0d cnt=%0d ovr=%b want 1 2047 0 0 65025 0",
                     bValid, bValue, bRow, bCol, bCount, bOverrun);
        end else begin
            passCnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", passCnt, totalCnt);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ramp();
        test_tie();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_reset_midscan();
        test_full_range();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
